// File: rtl/qcl_timer_pkg.sv
// ---------------------------------------------------------------------------
// qcl_timer_pkg
//   Shared types for the qcl pulse timer: per-channel FSM state and timing
//   mode, plus a small helper that turns the raw mode bit into the enum.
// ---------------------------------------------------------------------------
package qcl_timer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef enum logic {
        ONE_SHOT = 1'b0,
        PERIODIC = 1'b1
    } mode_e;

    function automatic mode_e to_mode(input logic periodic);
        return periodic ? PERIODIC : ONE_SHOT;
    endfunction

endpackage : qcl_timer_pkg

// File: rtl/qcl_pulse_timer_chan.sv
// ---------------------------------------------------------------------------
// qcl_pulse_timer_chan
//   One independent delay/pulse timer channel.
//
//   Ports
//     clk_i       rising-edge clock
//     reset_i     asynchronous active-high reset
//     start_i     start strobe; samples cycles_i / periodic_i
//     cycles_i    delay N in cycles (N = 0 is rejected and flagged)
//     periodic_i  0 = one-shot, 1 = periodic
//     cancel_i    abort strobe (start wins when both are high)
//     pulse_o     registered single-cycle expiry pulse
//     restart_o   registered strobe: start accepted while running
//     err_o       registered strobe: start with N = 0
//     state_o     current FSM state (busy == RUN)
//
//   Handshake: start_i/cancel_i are single-cycle strobes with no back
//   pressure; every strobe is acted on in the cycle it is seen and its
//   effect is visible on the outputs in the following cycle.
//
//   Timing: cnt_q holds the number of cycles still to wait before the pulse
//   cycle. A start with N loads N-1, so the cycle in which cnt_q == 0 while
//   RUN is the pulse cycle (t+N). pulse_q is set one cycle early (when
//   cnt_q == 1, or directly at load time when N == 1), which keeps every
//   output registered. Storing N-1 means N = 2^W-1 never overflows.
// ---------------------------------------------------------------------------
module qcl_pulse_timer_chan
    import qcl_timer_pkg::*;
#(
    parameter int cnt_width_p = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   start_i,
    input  logic [cnt_width_p-1:0] cycles_i,
    input  logic                   periodic_i,
    input  logic                   cancel_i,
    output logic                   pulse_o,
    output logic                   restart_o,
    output logic                   err_o,
    output state_e                 state_o
);

    localparam logic [cnt_width_p-1:0] one_lp = cnt_width_p'(1);

    state_e                 state_q, state_d;
    mode_e                  mode_q, mode_d;
    logic [cnt_width_p-1:0] cnt_q, cnt_d;
    logic [cnt_width_p-1:0] period_q, period_d;
    logic                   pulse_q, pulse_d;
    logic                   restart_q, restart_d;
    logic                   err_q, err_d;

    logic start_ok;
    logic expire;

    // A start with N = 0 is treated as if no start were present.
    assign start_ok = start_i && (cycles_i != '0);
    assign expire   = (state_q == RUN) && (cnt_q == '0);

    // State register (plus all datapath/output registers).
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            mode_q    <= ONE_SHOT;
            cnt_q     <= '0;
            period_q  <= '0;
            pulse_q   <= 1'b0;
            restart_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            pulse_q   <= pulse_d;
            restart_q <= restart_d;
            err_q     <= err_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (start_ok) begin
            state_d = RUN;
        end else if (state_q == RUN) begin
            if (cancel_i) begin
                state_d = IDLE;
            end else if (expire && (mode_q == ONE_SHOT)) begin
                state_d = IDLE;
            end
        end
    end

    // Output / datapath next values.
    always_comb begin
        mode_d    = mode_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        pulse_d   = 1'b0;
        restart_d = 1'b0;
        err_d     = start_i && (cycles_i == '0);
        if (start_ok) begin
            // New timing replaces whatever was running; any pending old
            // pulse is dropped because pulse_d only reflects the new N.
            mode_d    = to_mode(periodic_i);
            period_d  = cycles_i;
            cnt_d     = cycles_i - one_lp;
            pulse_d   = (cycles_i == one_lp);
            restart_d = (state_q == RUN);
        end else if ((state_q == RUN) && !cancel_i) begin
            if (expire) begin
                if (mode_q == PERIODIC) begin
                    cnt_d   = period_q - one_lp;
                    pulse_d = (period_q == one_lp);
                end
            end else begin
                cnt_d   = cnt_q - one_lp;
                pulse_d = (cnt_q == one_lp);
            end
        end else begin
            cnt_d = '0;
        end
    end

    assign pulse_o   = pulse_q;
    assign restart_o = restart_q;
    assign err_o     = err_q;
    assign state_o   = state_q;

endmodule : qcl_pulse_timer_chan

// File: rtl/qcl_pulse_timer.sv
// ---------------------------------------------------------------------------
// qcl_pulse_timer
//   Bank of channels_p fully independent programmable delay timers, each
//   one-shot or periodic, with restart and zero-delay error reporting.
//
//   Ports
//     clk_i       rising-edge clock
//     reset_i     asynchronous active-high reset
//     start_i     [channels_p]            per-channel start strobe
//     cycles_i    [channels_p*cnt_width_p] per-channel delay N,
//                 channel k at [k*cnt_width_p +: cnt_width_p]
//     periodic_i  [channels_p]            per-channel mode at start
//     cancel_i    [channels_p]            per-channel abort strobe
//     pulse_o     [channels_p]            expiry pulse
//     busy_o      [channels_p]            channel is timing
//     restart_o   [channels_p]            start accepted while busy
//     err_o       [channels_p]            start with N = 0
//
//   All outputs come straight from flops inside the channels; busy_o is the
//   decoded channel state register.
// ---------------------------------------------------------------------------
module qcl_pulse_timer
    import qcl_timer_pkg::*;
#(
    parameter int channels_p  = 4,
    parameter int cnt_width_p = 16
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic [channels_p-1:0]             start_i,
    input  logic [channels_p*cnt_width_p-1:0] cycles_i,
    input  logic [channels_p-1:0]             periodic_i,
    input  logic [channels_p-1:0]             cancel_i,
    output logic [channels_p-1:0]             pulse_o,
    output logic [channels_p-1:0]             busy_o,
    output logic [channels_p-1:0]             restart_o,
    output logic [channels_p-1:0]             err_o
);

    if (channels_p < 1 || channels_p > 32) begin : g_bad_channels
        $fatal(1, "qcl_pulse_timer: channels_p=%0d out of range 1..32", channels_p);
    end
    if (cnt_width_p < 1) begin : g_bad_width
        $fatal(1, "qcl_pulse_timer: cnt_width_p=%0d must be >= 1", cnt_width_p);
    end

    state_e chan_state [channels_p];

    for (genvar k = 0; k < channels_p; k++) begin : g_chan
        qcl_pulse_timer_chan #(
            .cnt_width_p (cnt_width_p)
        ) u_chan (
            .clk_i      (clk_i),
            .reset_i    (reset_i),
            .start_i    (start_i[k]),
            .cycles_i   (cycles_i[k*cnt_width_p +: cnt_width_p]),
            .periodic_i (periodic_i[k]),
            .cancel_i   (cancel_i[k]),
            .pulse_o    (pulse_o[k]),
            .restart_o  (restart_o[k]),
            .err_o      (err_o[k]),
            .state_o    (chan_state[k])
        );
        assign busy_o[k] = (chan_state[k] == RUN);
    end

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        for (int k = 0; k < channels_p; k++) begin
            if (!reset_i && restart_o[k]) begin
                $warning("qcl_pulse_timer: channel %0d restarted while busy", k);
            end
        end
    end
`endif

endmodule : qcl_pulse_timer

// File: tb/tb_qcl_pulse_timer.sv
// Testbench for qcl_pulse_timer: directed vector tables for the documented
// scenarios, reset behaviour, maximum delay, and randomized traffic against
// a deadline-based reference model.
module tb_qcl_pulse_timer;

    localparam int CH = 4;
    localparam int W  = 16;
    localparam int VW = 4 * CH;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [CH-1:0]   start, periodic, cancel;
    logic [CH*W-1:0] cycles;
    logic [CH-1:0]   pulse_o, busy_o, restart_o, err_o;

    qcl_pulse_timer #(
        .channels_p  (CH),
        .cnt_width_p (W)
    ) dut (
        .clk_i      (clk),
        .reset_i    (rst),
        .start_i    (start),
        .cycles_i   (cycles),
        .periodic_i (periodic),
        .cancel_i   (cancel),
        .pulse_o    (pulse_o),
        .busy_o     (busy_o),
        .restart_o  (restart_o),
        .err_o      (err_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Each channel tracks an absolute deadline (cycle number of the next
    // pulse); outputs for cycle mt+1 are derived from inputs seen in mt.
    longint mt;
    bit     m_act  [CH];
    bit     m_busy [CH];
    bit     m_perd [CH];
    longint m_dl   [CH];
    longint m_per  [CH];

    logic [VW-1:0] exp_q[$];

    function automatic void model_reset();
        for (int k = 0; k < CH; k++) begin
            m_act[k]  = 0;
            m_busy[k] = 0;
            m_perd[k] = 0;
            m_dl[k]   = 0;
            m_per[k]  = 0;
        end
    endfunction

    function automatic logic [VW-1:0] model_eval();
        logic [CH-1:0] o_p, o_b, o_r, o_e;
        longint n;
        o_p = '0; o_b = '0; o_r = '0; o_e = '0;
        for (int k = 0; k < CH; k++) begin
            n = longint'(cycles[k*W +: W]);
            o_e[k] = start[k] && (n == 0);
            if (start[k] && n != 0) begin
                o_r[k]    = m_busy[k];
                m_act[k]  = 1;
                m_dl[k]   = mt + n;
                m_per[k]  = n;
                m_perd[k] = periodic[k];
            end else if (cancel[k]) begin
                m_act[k] = 0;
            end
            o_b[k] = m_act[k];
            o_p[k] = m_act[k] && (m_dl[k] == mt + 1);
            if (o_p[k]) begin
                if (m_perd[k]) m_dl[k] = m_dl[k] + m_per[k];
                else           m_act[k] = 0;
            end
            m_busy[k] = o_b[k];
        end
        return {o_p, o_b, o_r, o_e};
    endfunction

    // ---------------- driver ----------------
    task automatic clear_inputs();
        start = '0; periodic = '0; cancel = '0; cycles = '0;
    endtask

    task automatic drive_ch(input int ch, input bit st, input int n, input bit per, input bit can);
        start[ch]          = st;
        cycles[ch*W +: W]  = W'(n);
        periodic[ch]       = per;
        cancel[ch]         = can;
    endtask

    // One clock: model predicts, DUT advances, scoreboard compares.
    task automatic step();
        logic [VW-1:0] e;
        exp_q.push_back(model_eval());
        @(posedge clk);
        #1;
        mt++;
        e = exp_q.pop_front();
        check($sformatf("model_cyc%0d", mt), 64'({pulse_o, busy_o, restart_o, err_o}), 64'(e));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int ch; bit st; int n; bit per; bit can;
        bit ep; bit eb; bit er; bit ee;   // channel outputs in the next cycle
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(int ch, bit st, int n, bit per, bit can,
                               bit ep, bit eb, bit er, bit ee);
        vec_t r;
        r.ch = ch; r.st = st; r.n = n; r.per = per; r.can = can;
        r.ep = ep; r.eb = eb; r.er = er; r.ee = ee;
        return r;
    endfunction

    initial begin
        int seen;
        int pc;
        int r;

        clear_inputs();
        model_reset();
        mt  = 0;
        rst = 1'b1;
        #1;
        check("reset_state", 64'({pulse_o, busy_o, restart_o, err_o}), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // One-shot ch0 N=4: pulse only at +4, busy +1..+4.
        tbl.push_back(v(0, 1, 4, 0, 0, 0, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Periodic ch1 N=3, cancel at +7: pulses +3,+6; busy low from +8.
        tbl.push_back(v(1, 1, 3, 1, 0, 0, 1, 0, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(v(1, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0));
        // Restart ch2: N=10 at 0, N=2 at 5 -> restart at 6, pulse at 7 only.
        tbl.push_back(v(2, 1, 10, 0, 0, 0, 1, 0, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(v(2, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(v(2, 1, 2, 0, 0, 0, 1, 1, 0));
        tbl.push_back(v(2, 0, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(v(2, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(2, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(2, 0, 0, 0, 0, 0, 0, 0, 0));
        // Error ch3: N=6 at 0, N=0 start at 2 -> err at 3, pulse still at 6.
        tbl.push_back(v(3, 1, 6, 0, 0, 0, 1, 0, 0));
        tbl.push_back(v(3, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(v(3, 1, 0, 1, 0, 0, 1, 0, 1));
        tbl.push_back(v(3, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(v(3, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(v(3, 0, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(v(3, 0, 0, 0, 0, 0, 0, 0, 0));
        // Start+cancel together: start wins (idle, then busy -> restart).
        tbl.push_back(v(3, 1, 2, 0, 1, 0, 1, 0, 0));
        tbl.push_back(v(3, 1, 3, 0, 1, 0, 1, 1, 0));
        tbl.push_back(v(3, 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(v(3, 0, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(v(3, 0, 0, 0, 0, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            clear_inputs();
            drive_ch(tbl[i].ch, tbl[i].st, tbl[i].n, tbl[i].per, tbl[i].can);
            step();
            check($sformatf("vec%0d_ch%0d", i, tbl[i].ch),
                  64'({pulse_o[tbl[i].ch], busy_o[tbl[i].ch], restart_o[tbl[i].ch], err_o[tbl[i].ch]}),
                  64'({tbl[i].ep, tbl[i].eb, tbl[i].er, tbl[i].ee}));
        end
        clear_inputs();

        // Async reset mid-count with every channel busy.
        for (int k = 0; k < CH; k++) drive_ch(k, 1, 20 + k, k[0], 0);
        step();
        clear_inputs();
        repeat (4) step();
        check("busy_before_reset", 64'(busy_o), 64'({CH{1'b1}}));
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_outputs", 64'({pulse_o, busy_o, restart_o, err_o}), 64'(0));
        for (int k = 0; k < CH; k++) drive_ch(k, 1, 3, 0, 1);
        @(posedge clk);
        #1;
        check("reset_ignores_start", 64'({pulse_o, busy_o, restart_o, err_o}), 64'(0));
        rst = 1'b0;
        clear_inputs();
        model_reset();
        exp_q.delete();
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (pulse_o != '0 || busy_o != '0) seen++;
        end
        check("no_activity_after_reset", 64'(seen), 64'(0));

        // Maximum delay on ch0: exactly one pulse, 65535 cycles after start.
        drive_ch(0, 1, 65535, 0, 0);
        seen = 0;
        pc   = -1;
        for (r = 1; r <= 65536; r++) begin
            step();
            if (r == 1) clear_inputs();
            if (pulse_o[0]) begin
                seen++;
                pc = r;
            end
        end
        check("maxn_pulse_count", 64'(seen), 64'(1));
        check("maxn_pulse_cycle", 64'(pc), 64'(65535));
        check("maxn_busy_after", 64'(busy_o[0]), 64'(0));

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            clear_inputs();
            for (int k = 0; k < CH; k++) begin
                if ($urandom_range(0, 7) == 0) begin
                    drive_ch(k, 1, ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12)),
                             bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) == 0));
                end else begin
                    drive_ch(k, 0, int'($urandom_range(0, 20)), bit'($urandom_range(0, 1)),
                             bit'($urandom_range(0, 15) == 0));
                end
            end
            step();
        end
        clear_inputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_qcl_pulse_timer
